// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter granting one JK update per two cycles on a shared bit bank
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IW    = 3
) (
  input  logic                 CK,
  input  logic                 RB,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      J,
  input  logic [NREQ-1:0]      K,
  input  logic [NREQ*IW-1:0]   IDX,
  output logic [NREQ-1:0]      ACK,
  output logic                 BUSY,
  output logic [WIDTH-1:0]     Q
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {IDLE, APPLY} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic j_q, j_d, k_q, k_d, found;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] q_q, q_d, mask;
  // Round-robin search: first requester at or above ptr_q, wrapping to 0
  always_comb begin
    int c;
    c = 0;
    pick = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      c = (int'(ptr_q) + i) % NREQ;
      if (!found && REQ[c]) begin
        found = 1'b1;
        pick = PW'(c);
      end
    end
  end
  // Next state: latch the winner in IDLE, commit the JK op to one bank bit in APPLY
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    j_d = j_q;
    k_d = k_q;
    idx_d = idx_q;
    q_d = q_q;
    mask = (int'(idx_q) < WIDTH) ? WIDTH'(1) << idx_q : '0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = APPLY;
        win_d = pick;
        j_d = J[pick];
        k_d = K[pick];
        idx_d = IDX[int'(pick)*IW +: IW];
      end
    end else begin
      state_d = IDLE;
      ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
      q_d = (j_q && k_q) ? q_q ^ mask : j_q ? q_q | mask : k_q ? q_q & ~mask : q_q;
    end
  end
  // State registers; reset discards any pending operation
  always_ff @(posedge CK) begin
    if (!RB) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      j_q <= 1'b0;
      k_q <= 1'b0;
      idx_q <= '0;
      q_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      j_q <= j_d;
      k_q <= k_d;
      idx_q <= idx_d;
      q_q <= q_d;
    end
  end
  assign ACK = (state_q == APPLY) ? NREQ'(1) << win_q : '0;
  assign BUSY = (state_q == APPLY);
  assign Q = q_q;
endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the number of JK bits in the bank (power of 2, 2..32).
REQ-003 Parameter IW, default 3, SHALL set the bit-index width; the integrator SHALL set it to log2(WIDTH).
REQ-004 Port CK, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port RB, input, 1: reset; it SHALL be synchronous and active-low.
REQ-006 Port REQ, input, NREQ: REQ[i]=1 SHALL mean requester i asks for one bank operation.
REQ-007 Port J, input, NREQ: J[i] SHALL be the J code of requester i.
REQ-008 Port K, input, NREQ: K[i] SHALL be the K code of requester i.
REQ-009 Port IDX, input, NREQ*IW: slice [i*IW +: IW] SHALL be the target bit index of requester i.
REQ-010 Port ACK, output, NREQ: ACK[i]=1 SHALL mark the cycle in which the operation of requester i commits.
REQ-011 Port BUSY, output, 1: BUSY SHALL be 1 while an operation is latched and not yet committed.
REQ-012 Port Q, output, WIDTH: the current value of the JK bank.

Function
REQ-013 The FSM SHALL have two states: IDLE and APPLY.
REQ-014 In IDLE with REQ all zero, the block SHALL stay in IDLE and hold Q.
REQ-015 In IDLE with any REQ bit set, the block SHALL pick a winner by round-robin, starting at pointer PTR and searching upward with wrap from NREQ-1 to 0.
REQ-016 On that edge, the block SHALL latch the winner's number, its J, K and IDX, and move to APPLY.
REQ-017 In APPLY, the ACK bit of the latched winner SHALL be 1 and all other ACK bits SHALL be 0; ACK SHALL decode only from registered state.
REQ-018 On the edge that ends APPLY, the block SHALL update only bit Q[IDX] with the latched {J,K}: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-019 On the same edge, the block SHALL set PTR to (winner+1) mod NREQ and return to IDLE.
REQ-020 BUSY SHALL be 1 exactly in APPLY.
REQ-021 Latency SHALL be 2 cycles from REQ sampled high in IDLE to the Q update; ACK SHALL be high in the second cycle.
REQ-022 Maximum throughput SHALL be one operation per 2 cycles.
REQ-023 The block SHALL ignore inputs in APPLY; changing REQ, J, K or IDX then SHALL NOT affect the pending operation.
REQ-024 A requester SHALL drop REQ in the cycle after it sees ACK, or it is re-arbitrated as a new request.
REQ-025 An IDX value >= WIDTH SHALL commit as a no-op: ACK still pulses and Q is unchanged.
REQ-026 Dropping REQ while in APPLY SHALL NOT cancel the latched operation.
REQ-027 With all requesters asking continuously, each SHALL be served once every NREQ operations, with no starvation.

Reset
REQ-028 RB=0 at a rising edge SHALL force Q=0, state IDLE, PTR=0, ACK=0 and BUSY=0.
REQ-029 Reset SHALL override every other input, including during APPLY; the pending operation SHALL be discarded with no Q update and no further ACK.
REQ-030 In the first cycle after RB returns to 1, the block SHALL be in IDLE and able to accept requests.

Verification
REQ-031 Reset then single op: REQ[0]=1, J=1, K=0, IDX0=3 -> next cycle BUSY=1, ACK[0]=1; following cycle Q=8'h08.
REQ-032 Toggle and clear: after Q=8'h08, requester 2 sends {1,1} on IDX 3 -> Q=8'h00; then {1,1} on IDX 7 -> Q=8'h80; then {0,1} on IDX 7 -> Q=8'h00.
REQ-033 Round-robin fairness: REQ=4'b1111 held, all set ops on distinct bits -> ACK order is 0,1,2,3,0, one ACK every 2 cycles.
REQ-034 Pointer wrap: PTR=3 after serving requester 2, REQ=4'b1001 -> requester 3 is served first, then requester 0.
REQ-035 Reset mid-operation: RB=0 on the edge ending APPLY for a set op on bit 5 -> Q=8'h00, ACK=0, BUSY=0 on the next cycle.
REQ-036 Out-of-range and hold: IDX=7 with WIDTH=4 (IW=3), and separately {J,K}=00 -> ACK pulses once and Q is unchanged in both cases.
